shake_arbiter: RTL and testbench

//  Shares one SHAKE256 core (keccak_top) between NUM_REQ requesters, e.g. seedexpander, hash-G, hash-K.

---
 rtl/shake_arbiter_pkg.sv | 18 +
 rtl/shake_arbiter_rr_picker.sv | 39 +++
 rtl/shake_arbiter.sv | 140 ++++++++++++++
 tb/tb_shake_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_arbiter_pkg.sv
// Shared definitions for the SHAKE256 core arbiter.
//   arb_state_e : arbiter FSM states (idle, granted, flushing the core, one-cycle cool-down)
//   ptr_width() : width of the round-robin pointer / requester index for a given requester count
package shake_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StFlush = 2'd2,
        StCool  = 2'd3
    } arb_state_e;

    // At least one bit, so a two-requester build still has a usable index.
    function automatic int unsigned ptr_width(input int unsigned num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/shake_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req      : request vector
//   ptr      : index with highest priority this round
//   pick     : one-hot of the first set request at or after ptr (wrapping), zero if none
//   pick_idx : binary index of pick (zero if none)
module shake_arbiter_rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx
);

    logic found;

    // Pass 1 searches indices >= ptr; pass 2 wraps around to the lowest set bit.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                pick[i]  = 1'b1;
                pick_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                pick[i]  = 1'b1;
                pick_idx = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/shake_arbiter.sv
// Round-robin arbiter sharing one SHAKE256 core between NUM_REQ requesters.
// A grant is held for a whole absorb/squeeze transaction; on release the core is
// forced idle (force_done/ack) and drained before the next grant.
//   clk, rst            : clock, synchronous active-low reset
//   req, release_i      : level requests, one-cycle release pulse from the granted requester
//   grant, busy         : registered one-hot grant, arbiter not idle
//   req_din*, req_dout* : per-requester streams (dout data broadcast, valid/ready per requester)
//   core_*              : streams and force_done handshake toward the core
module shake_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned WIN     = 32,
    parameter int unsigned WOUT    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     release_i,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    input  logic [NUM_REQ*WIN-1:0] req_din,
    input  logic [NUM_REQ-1:0]     req_din_valid,
    output logic [NUM_REQ-1:0]     req_din_ready,
    output logic [WOUT-1:0]        req_dout,
    output logic [NUM_REQ-1:0]     req_dout_valid,
    input  logic [NUM_REQ-1:0]     req_dout_ready,
    output logic [WIN-1:0]         core_din,
    output logic                   core_din_valid,
    input  logic                   core_din_ready,
    input  logic [WOUT-1:0]        core_dout,
    input  logic                   core_dout_valid,
    output logic                   core_dout_ready,
    output logic                   core_force_done,
    input  logic                   core_force_done_ack
);

    import shake_arbiter_pkg::*;

    localparam int unsigned PtrW = ptr_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PtrW-1:0]    idx_q, idx_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0] pick;
    logic [PtrW-1:0]    pick_idx;

    shake_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PtrW)
    ) u_picker (
        .req      (req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                    grant_d = pick;
                    idx_d   = pick_idx;
                    ptr_d   = (pick_idx == PtrW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            StGrant: begin
                // Releases from anyone other than the owner are ignored.
                if (release_i[idx_q]) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (core_force_done_ack) begin
                    state_d = StCool;
                    grant_d = '0;
                end
            end
            StCool: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Stream routing; only the granted requester sees the core, and only while in StGrant.
    always_comb begin
        core_din        = req_din[32'(idx_q) * WIN +: WIN];
        core_din_valid  = 1'b0;
        core_dout_ready = 1'b0;
        core_force_done = 1'b0;
        req_din_ready   = '0;
        req_dout_valid  = '0;
        unique case (state_q)
            StGrant: begin
                core_din_valid        = req_din_valid[idx_q];
                core_dout_ready       = req_dout_ready[idx_q];
                req_din_ready[idx_q]  = core_din_ready;
                req_dout_valid[idx_q] = core_dout_valid;
            end
            StFlush: begin
                // Leftover squeeze output is accepted and thrown away.
                core_force_done = 1'b1;
                core_dout_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign req_dout = core_dout;
    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);

    grant_onehot_a: assert property (@(posedge clk) $onehot0(grant_q));

endmodule

// File: tb/tb_shake_arbiter.sv
// Self-checking bench for shake_arbiter with a scoreboard: stimulus pushes expected
// grants, core input words and requester output words; a negedge monitor pops and compares.
module tb_shake_arbiter;

    localparam int unsigned N = 3;
    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   release_i = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [N*W-1:0] req_din = '0;
    logic [N-1:0]   req_din_valid = '0;
    logic [N-1:0]   req_din_ready;
    logic [W-1:0]   req_dout;
    logic [N-1:0]   req_dout_valid;
    logic [N-1:0]   req_dout_ready = '0;
    logic [W-1:0]   core_din;
    logic           core_din_valid;
    logic           core_din_ready = 1'b0;
    logic [W-1:0]   core_dout;
    logic           core_dout_valid;
    logic           core_dout_ready;
    logic           core_force_done;
    logic           core_force_done_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [N-1:0]  exp_grant[$];
    logic [W-1:0]  exp_din[$];
    logic [63:0]   exp_dout[$];
    logic [N-1:0]  grant_prev = '0;
    logic          ignore_din = 1'b0;

    shake_arbiter #(
        .NUM_REQ (N),
        .WIN     (W),
        .WOUT    (W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (req),
        .release_i           (release_i),
        .grant               (grant),
        .busy                (busy),
        .req_din             (req_din),
        .req_din_valid       (req_din_valid),
        .req_din_ready       (req_din_ready),
        .req_dout            (req_dout),
        .req_dout_valid      (req_dout_valid),
        .req_dout_ready      (req_dout_ready),
        .core_din            (core_din),
        .core_din_valid      (core_din_valid),
        .core_din_ready      (core_din_ready),
        .core_dout           (core_dout),
        .core_dout_valid     (core_dout_valid),
        .core_dout_ready     (core_dout_ready),
        .core_force_done     (core_force_done),
        .core_force_done_ack (core_force_done_ack)
    );

    initial forever #5 clk = ~clk;

    // Core model: din ready pattern 1,1,0; squeeze words from sq_mem; ack echoes force_done.
    int          cyc = 0;
    int          sq_rd = 0;
    int          sq_cnt = 0;
    logic [31:0] sq_mem [0:31];

    always @(posedge clk) begin
        cyc                 <= cyc + 1;
        core_din_ready      <= (cyc % 3) != 2;
        core_force_done_ack <= core_force_done;
        if (core_dout_valid && core_dout_ready) sq_rd <= sq_rd + 1;
    end
    assign core_dout_valid = (sq_rd != sq_cnt);
    assign core_dout       = sq_mem[sq_rd[4:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s got=%h expected=none", name, act);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (core_din_valid && core_din_ready && !ignore_din) begin
            if (exp_din.size() == 0) extra("din_extra", 64'(core_din));
            else chk("core_din", 64'(core_din), 64'(exp_din.pop_front()));
        end
        for (int k = 0; k < int'(N); k++) begin
            if (req_dout_valid[k] && req_dout_ready[k]) begin
                if (exp_dout.size() == 0) extra("dout_extra", {32'(k), req_dout});
                else chk("req_dout", {32'(k), req_dout}, exp_dout.pop_front());
            end
        end
        if (grant !== grant_prev) begin
            if (grant != '0) begin
                if (exp_grant.size() == 0) extra("grant_extra", 64'(grant));
                else chk("grant_order", 64'(grant), 64'(exp_grant.pop_front()));
            end
            grant_prev <= grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 30) begin tick(); n++; end
        if (grant == '0) extra("wait_grant_timeout", 64'(n));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin tick(); n++; end
        if (busy) extra("wait_idle_timeout", 64'(n));
    endtask

    task automatic send_word(input int k, input logic [31:0] w);
        int n = 0;
        exp_din.push_back(w);
        req_din[k*W +: W] = w;
        req_din_valid[k]  = 1'b1;
        while (!req_din_ready[k] && n < 30) begin tick(); n++; end
        if (!req_din_ready[k]) extra("send_word_timeout", 64'(w));
        tick();
        req_din_valid[k] = 1'b0;
    endtask

    task automatic release_grant();
        release_i = grant;
        tick();
        release_i = '0;
        wait_idle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int k;
        logic [31:0] hold;
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] w;

        // 1) Reset held with all requests active.
        rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", 64'(grant), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_force_done", 64'(core_force_done), 64'(0));
        end
        req = '0;
        rst = 1'b1;
        tick();

        // 2) Single requester: grant latency, 4 din words, 8 squeeze words with toggled ready.
        exp_grant.push_back(3'b010);
        req = 3'b010;
        #1;
        chk("grant_before_edge", 64'(grant), 64'(0));
        tick();
        chk("grant_latency", 64'(grant), 64'(3'b010));
        chk("busy_granted", 64'(busy), 64'(1));
        for (int i = 0; i < 4; i++) send_word(1, 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            w = 32'hB000_0000 + 32'(i * 7);
            sq_mem[sq_cnt[4:0]] = w;
            sq_cnt++;
            exp_dout.push_back({32'd1, w});
        end
        for (int i = 0; i < 60 && sq_rd != sq_cnt; i++) begin
            req_dout_ready[1] = ~req_dout_ready[1];
            tick();
        end
        req_dout_ready = '0;
        tick();
        chk("squeeze_all_received", 64'(exp_dout.size()), 64'(0));

        // 3) Release and flush; leftover squeeze words must be drained silently.
        for (int i = 0; i < 2; i++) begin
            sq_mem[sq_cnt[4:0]] = 32'hDEAD_0000 + 32'(i);
            sq_cnt++;
        end
        req = '0;
        release_i = 3'b010;
        tick();
        release_i = '0;
        chk("flush1_force_done", 64'(core_force_done), 64'(1));
        chk("flush1_grant", 64'(grant), 64'(3'b010));
        chk("flush1_dout_ready", 64'(core_dout_ready), 64'(1));
        chk("flush1_req_dout_valid", 64'(req_dout_valid), 64'(0));
        tick();
        chk("flush2_force_done", 64'(core_force_done), 64'(1));
        tick();
        chk("cool_grant", 64'(grant), 64'(0));
        chk("cool_force_done", 64'(core_force_done), 64'(0));
        chk("cool_busy", 64'(busy), 64'(1));
        tick();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("flush_drained", 64'(sq_cnt - sq_rd), 64'(0));

        // 4) Round robin from a fresh pointer.
        do_reset();
        exp_grant.push_back(3'b001);
        exp_grant.push_back(3'b010);
        exp_grant.push_back(3'b100);
        exp_grant.push_back(3'b001);
        req = 3'b111;
        for (int r = 0; r < 4; r++) begin
            wait_grant();
            k = 0;
            for (int b = 0; b < int'(N); b++) if (grant[b]) k = b;
            send_word(k, 32'h4000_0000 + 32'(r * 16));
            send_word(k, 32'h4000_0001 + 32'(r * 16));
            if (r == 3) req = '0;
            release_grant();
        end
        chk("rr_all_grants", 64'(exp_grant.size()), 64'(0));

        // 5) Foreign release ignored, request drop ignored, non-granted valid blocked.
        exp_grant.push_back(3'b001);
        req = 3'b001;
        wait_grant();
        release_i = 3'b100;
        tick();
        release_i = '0;
        tick();
        chk("foreign_release_grant", 64'(grant), 64'(3'b001));
        chk("foreign_release_busy", 64'(busy), 64'(1));
        chk("foreign_release_fd", 64'(core_force_done), 64'(0));
        req = '0;
        tick();
        tick();
        chk("req_drop_grant", 64'(grant), 64'(3'b001));
        for (int i = 0; i < 5 && !core_din_ready; i++) tick();
        req_din[1*W +: W] = 32'h5555_0001;
        req_din[2*W +: W] = 32'h5555_0002;
        req_din_valid = 3'b110;
        #1;
        chk("foreign_valid_blocked", 64'(core_din_valid), 64'(0));
        chk("foreign_ready", 64'(req_din_ready), 64'(3'b001));
        req_din_valid = '0;
        send_word(0, 32'hCAFE_0005);
        release_grant();

        // 6) Reset mid-grant with a valid word pending, then pointer restarts at 0.
        exp_grant.push_back(3'b010);
        req = 3'b010;
        wait_grant();
        ignore_din = 1'b1;
        req_din[1*W +: W] = 32'h6666_0001;
        req_din_valid[1] = 1'b1;
        #1;
        chk("pre_rst_din_valid", 64'(core_din_valid), 64'(1));
        chk("pre_rst_din", 64'(core_din), 64'(32'h6666_0001));
        rst = 1'b0;
        tick();
        chk("mid_rst_grant", 64'(grant), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_din_valid", 64'(core_din_valid), 64'(0));
        chk("mid_rst_din_ready", 64'(req_din_ready), 64'(0));
        chk("mid_rst_dout_ready", 64'(core_dout_ready), 64'(0));
        chk("mid_rst_force_done", 64'(core_force_done), 64'(0));
        rst = 1'b1;
        req_din_valid = '0;
        #1;
        ignore_din = 1'b0;
        exp_grant.push_back(3'b010);
        req = 3'b110;
        tick();
        chk("post_rst_grant", 64'(grant), 64'(3'b010));
        req = '0;
        release_grant();

        tick();
        chk("grant_queue_left", 64'(exp_grant.size()), 64'(0));
        chk("din_queue_left", 64'(exp_din.size()), 64'(0));
        chk("dout_queue_left", 64'(exp_dout.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
